// File: rtl/word_byte_serializer.sv
// rtl/word_byte_serializer.sv - pops 32-bit words from a FIFO and emits them as a ready/valid byte stream
// One buffer of i_RCC_BUFFER_LENGTH words per accepted i_start; o_done pulses once the last byte is accepted.
module word_byte_serializer #(
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        i_start,
  input  logic [5:0]  i_RCC_BUFFER_LENGTH,
  input  logic        i_FIFO_empty,
  input  logic [31:0] i_FIFO_rd_data,
  output logic        o_FIFO_rd_en,
  input  logic        i_ready,
  output logic [7:0]  O_serialized_output,
  output logic        O_serialized_output_valid,
  output logic [1:0]  O_Serialize_Counter,
  output logic [15:0] O_Bytes_Counter,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  words_left_q, words_left_d;
  logic [31:0] hold_q, hold_d;
  logic [1:0]  ser_cnt_q, ser_cnt_d;
  logic [15:0] bytes_cnt_q, bytes_cnt_d;
  logic [1:0]  byte_idx;
  logic [7:0]  byte_sel;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= S_IDLE;
      words_left_q <= 6'd0;
      hold_q       <= 32'd0;
      ser_cnt_q    <= 2'd0;
      bytes_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      hold_q       <= hold_d;
      ser_cnt_q    <= ser_cnt_d;
      bytes_cnt_q  <= bytes_cnt_d;
    end
  end

  always_comb begin
    state_d                   = state_q;
    words_left_d              = words_left_q;
    hold_d                    = hold_q;
    ser_cnt_d                 = ser_cnt_q;
    bytes_cnt_d               = bytes_cnt_q;
    o_FIFO_rd_en              = 1'b0;
    O_serialized_output_valid = 1'b0;
    o_done                    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          words_left_d = i_RCC_BUFFER_LENGTH;
          bytes_cnt_d  = 16'd0;
          ser_cnt_d    = 2'd0;
          state_d      = (i_RCC_BUFFER_LENGTH == 6'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (!i_FIFO_empty) begin
          o_FIFO_rd_en = 1'b1;
          state_d      = S_LOAD;
        end
      end
      S_LOAD: begin
        // FIFO data arrives the cycle after the pop strobe
        hold_d  = i_FIFO_rd_data;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        O_serialized_output_valid = 1'b1;
        if (i_ready) begin
          ser_cnt_d   = ser_cnt_q + 2'd1;
          bytes_cnt_d = bytes_cnt_q + 16'd1;
          if (ser_cnt_q == 2'd3) begin
            words_left_d = words_left_q - 6'd1;
            state_d      = (words_left_q == 6'd1) ? S_DONE : S_FETCH;
          end
        end
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    byte_idx = LITTLE_ENDIAN ? ser_cnt_q : (2'd3 - ser_cnt_q);
    byte_sel = hold_q[{byte_idx, 3'b000} +: 8];
  end

  assign O_serialized_output = O_serialized_output_valid ? byte_sel : 8'd0;
  assign O_Serialize_Counter = ser_cnt_q;
  assign O_Bytes_Counter     = bytes_cnt_q;
  assign o_busy              = (state_q != S_IDLE);

endmodule

// File: tb/tb_word_byte_serializer.sv
// tb/tb_word_byte_serializer.sv - directed bench for word_byte_serializer, both byte orders side by side
module tb_word_byte_serializer;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        i_start;
  logic [5:0]  len;
  logic        i_ready;
  logic        i_FIFO_empty;
  logic [31:0] fifo_rd_data = 32'd0;

  logic        le_rd_en, le_valid, le_busy, le_done;
  logic [7:0]  le_byte;
  logic [1:0]  le_cnt;
  logic [15:0] le_bcnt;
  logic        be_rd_en, be_valid, be_busy, be_done;
  logic [7:0]  be_byte;
  logic [1:0]  be_cnt;
  logic [15:0] be_bcnt;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  word_byte_serializer #(.LITTLE_ENDIAN(1'b1)) dut_le (
    .HCLK(HCLK), .HRESET(HRESET), .i_start(i_start), .i_RCC_BUFFER_LENGTH(len),
    .i_FIFO_empty(i_FIFO_empty), .i_FIFO_rd_data(fifo_rd_data), .o_FIFO_rd_en(le_rd_en),
    .i_ready(i_ready), .O_serialized_output(le_byte), .O_serialized_output_valid(le_valid),
    .O_Serialize_Counter(le_cnt), .O_Bytes_Counter(le_bcnt), .o_busy(le_busy), .o_done(le_done)
  );

  word_byte_serializer #(.LITTLE_ENDIAN(1'b0)) dut_be (
    .HCLK(HCLK), .HRESET(HRESET), .i_start(i_start), .i_RCC_BUFFER_LENGTH(len),
    .i_FIFO_empty(i_FIFO_empty), .i_FIFO_rd_data(fifo_rd_data), .o_FIFO_rd_en(be_rd_en),
    .i_ready(i_ready), .O_serialized_output(be_byte), .O_serialized_output_valid(be_valid),
    .O_Serialize_Counter(be_cnt), .O_Bytes_Counter(be_bcnt), .o_busy(be_busy), .o_done(be_done)
  );

  // Upstream FIFO model, popped by the little-endian instance
  logic [31:0] mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign i_FIFO_empty = (rd_ptr >= wr_ptr);

  always @(posedge HCLK) begin
    if (le_rd_en) begin
      fifo_rd_data <= mem[rd_ptr[5:0]];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  logic [7:0] rx_le [$];
  logic [7:0] rx_be [$];
  logic [1:0] rx_cnt [$];
  int n_done = 0, n_valid = 0, n_rd_empty = 0, n_stall = 0, n_hold_err = 0;
  logic       p_valid = 1'b0, p_ready = 1'b0;
  logic [7:0] p_byte = 8'd0;
  logic [1:0] p_cnt = 2'd0;

  always @(negedge HCLK) begin
    if (!HRESET) begin
      if (le_valid && i_ready) begin
        rx_le.push_back(le_byte);
        rx_be.push_back(be_byte);
        rx_cnt.push_back(le_cnt);
      end
      if (le_done) n_done <= n_done + 1;
      if (le_valid) n_valid <= n_valid + 1;
      if (le_rd_en && i_FIFO_empty) n_rd_empty <= n_rd_empty + 1;
      if (le_busy && i_FIFO_empty && !le_rd_en && !le_valid) n_stall <= n_stall + 1;
      if (p_valid && !p_ready && (!le_valid || le_byte != p_byte || le_cnt != p_cnt))
        n_hold_err <= n_hold_err + 1;
    end
    p_valid <= le_valid;
    p_ready <= i_ready;
    p_byte  <= le_byte;
    p_cnt   <= le_cnt;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr++;
  endtask

  // Ends on the negedge of the first cycle after the start is taken
  task automatic start_buf(input logic [5:0] n);
    @(posedge HCLK); #1;
    len = n;
    i_start = 1'b1;
    @(posedge HCLK); #1;
    i_start = 1'b0;
    @(negedge HCLK);
  endtask

  task automatic wait_done(input int budget, input bit toggle, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge HCLK); #1;
      i_ready = toggle ? ~i_ready : 1'b1;
      @(negedge HCLK);
      if (le_done) begin
        ok = 1'b1;
        break;
      end
    end
    i_ready = 1'b1;
  endtask

  function automatic logic [7:0] ebyte(input logic [31:0] w, input int k, input bit le);
    return le ? w[8*k +: 8] : w[8*(3-k) +: 8];
  endfunction

  task automatic check_stream(input string tag, input int b, input logic [31:0] w [4], input int nw);
    chk({tag, "_nbytes"}, rx_le.size() - b, 4 * nw);
    if (rx_le.size() - b == 4 * nw) begin
      for (int k = 0; k < 4 * nw; k++) begin
        chk($sformatf("%s_le_b%0d", tag, k), rx_le[b+k], ebyte(w[k/4], k % 4, 1'b1));
        chk($sformatf("%s_be_b%0d", tag, k), rx_be[b+k], ebyte(w[k/4], k % 4, 1'b0));
        chk($sformatf("%s_cnt_b%0d", tag, k), rx_cnt[b+k], k % 4);
      end
    end
  endtask

  logic [7:0]  e_le    [8] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};
  logic [7:0]  e_be    [8] = '{8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00, 8'h00};
  logic        e_valid [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [1:0]  e_cnt   [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
  logic [15:0] e_bcnt  [8] = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd4};
  logic        e_done  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        e_rd    [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        e_busy  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int b, pops0, done0, stall0, hold0, valid0;
    bit ok, found;
    logic [31:0] w [4];

    HRESET = 1'b1; i_start = 1'b0; len = 6'd0; i_ready = 1'b1;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_busy", {le_busy, be_busy}, 2'b00);
    chk("rst_valid", {le_valid, be_valid}, 2'b00);
    chk("rst_byte", {le_byte, be_byte}, 16'h0000);
    chk("rst_cnt", {le_cnt, be_cnt}, 4'h0);
    chk("rst_bcnt", le_bcnt, 16'd0);
    chk("rst_done_rd", {le_done, le_rd_en}, 2'b00);
    @(posedge HCLK); #1;
    HRESET = 1'b0;

    // Single word, cycle-exact, both byte orders
    push(32'h44332211);
    start_buf(6'd1);
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("t1_valid_c%0d", c), le_valid, e_valid[c]);
      chk($sformatf("t1_le_c%0d", c), le_byte, e_le[c]);
      chk($sformatf("t1_be_c%0d", c), be_byte, e_be[c]);
      chk($sformatf("t1_cnt_c%0d", c), le_cnt, e_cnt[c]);
      chk($sformatf("t1_bcnt_c%0d", c), le_bcnt, e_bcnt[c]);
      chk($sformatf("t1_done_c%0d", c), le_done, e_done[c]);
      chk($sformatf("t1_rd_c%0d", c), le_rd_en, e_rd[c]);
      chk($sformatf("t1_busy_c%0d", c), le_busy, e_busy[c]);
      @(negedge HCLK);
    end
    chk("t1_pops", rd_ptr, 1);

    // Zero length: straight to DONE with no reads and no bytes
    pops0 = rd_ptr; valid0 = n_valid;
    start_buf(6'd0);
    chk("t2_done_c0", {le_done, le_busy, le_valid, le_rd_en}, 4'b1100);
    @(negedge HCLK);
    chk("t2_idle_c1", {le_done, le_busy}, 2'b00);
    chk("t2_bcnt", le_bcnt, 16'd0);
    chk("t2_pops", rd_ptr - pops0, 0);
    chk("t2_valid", n_valid - valid0, 0);

    // A start while busy must not restart the buffer
    b = rx_le.size(); pops0 = rd_ptr; done0 = n_done;
    w = '{32'hA3A2A1A0, 32'hB3B2B1B0, 32'h0, 32'h0};
    push(w[0]); push(w[1]);
    start_buf(6'd2);
    @(posedge HCLK); #1;
    len = 6'd5; i_start = 1'b1;
    @(posedge HCLK); #1;
    i_start = 1'b0;
    wait_done(60, 1'b0, ok);
    chk("t2b_done_seen", ok, 1'b1);
    chk("t2b_bcnt", le_bcnt, 16'd8);
    @(posedge HCLK); @(negedge HCLK);
    chk("t2b_pops", rd_ptr - pops0, 2);
    chk("t2b_ndone", n_done - done0, 1);
    chk("t2b_bcnt_hold", le_bcnt, 16'd8);
    check_stream("t2b", b, w, 2);

    // Three words with the FIFO running dry after the first
    b = rx_le.size(); pops0 = rd_ptr; stall0 = n_stall;
    w = '{32'h0D0C0B0A, 32'h1D1C1B1A, 32'h2D2C2B2A, 32'h0};
    push(w[0]);
    start_buf(6'd3);
    repeat (14) @(negedge HCLK);
    chk("t3_pops_stalled", rd_ptr - pops0, 1);
    chk("t3_stall_busy", le_busy, 1'b1);
    push(w[1]); push(w[2]);
    wait_done(80, 1'b0, ok);
    chk("t3_done_seen", ok, 1'b1);
    chk("t3_bcnt", le_bcnt, 16'd12);
    @(posedge HCLK); @(negedge HCLK);
    chk("t3_pops", rd_ptr - pops0, 3);
    chk("t3_stall_ge5", (n_stall - stall0) >= 5, 1'b1);
    chk("t3_rd_while_empty", n_rd_empty, 0);
    check_stream("t3", b, w, 3);

    // Backpressure: i_ready toggles every cycle
    b = rx_le.size(); hold0 = n_hold_err;
    w = '{32'h87654321, 32'hFEDCBA98, 32'h0, 32'h0};
    push(w[0]); push(w[1]);
    start_buf(6'd2);
    wait_done(120, 1'b1, ok);
    chk("t4_done_seen", ok, 1'b1);
    chk("t4_bcnt", le_bcnt, 16'd8);
    @(posedge HCLK); @(negedge HCLK);
    chk("t4_hold_err", n_hold_err - hold0, 0);
    check_stream("t4", b, w, 2);

    // Reset while byte 2 of word 2 is on the output
    pops0 = rd_ptr;
    push(32'h13121110); push(32'h23222120); push(32'h33323130);
    start_buf(6'd3);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge HCLK);
      if (le_valid && le_cnt == 2'd2 && (rd_ptr - pops0) == 2) begin
        found = 1'b1;
        break;
      end
    end
    chk("t5_reached_w2b2", found, 1'b1);
    chk("t5_byte_before", le_byte, 8'h22);
    done0 = n_done;
    HRESET = 1'b1;
    @(negedge HCLK);
    chk("t5_busy", {le_busy, be_busy}, 2'b00);
    chk("t5_valid", {le_valid, be_valid}, 2'b00);
    chk("t5_byte", {le_byte, be_byte}, 16'h0000);
    chk("t5_cnt", le_cnt, 2'd0);
    chk("t5_bcnt", le_bcnt, 16'd0);
    chk("t5_done_rd", {le_done, le_rd_en}, 2'b00);
    HRESET = 1'b0;
    repeat (10) @(negedge HCLK);
    chk("t5_no_done", n_done - done0, 0);
    chk("t5_pops", rd_ptr - pops0, 2);
    chk("t5_idle", le_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/word_byte_serializer.md
WORD_BYTE_SERIALIZER -- requirements
Module: word_byte_serializer

Interface
REQ-001 SHALL provide parameter LITTLE_ENDIAN, default 1, selecting byte order: 1 = bits[7:0] first, 0 = bits[31:24] first.
REQ-002 SHALL provide port HCLK  input  1  single clock for all sequential logic.
REQ-003 SHALL provide port HRESET  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL provide port i_start  input  1  single-cycle request to begin serializing one buffer.
REQ-005 SHALL provide port i_RCC_BUFFER_LENGTH  input  6  buffer length in 32-bit words, sampled on accepted i_start.
REQ-006 SHALL provide port i_FIFO_empty  input  1  upstream word FIFO empty flag.
REQ-007 SHALL provide port i_FIFO_rd_data  input  32  FIFO read data, valid the cycle after o_FIFO_rd_en.
REQ-008 SHALL provide port o_FIFO_rd_en  output  1  FIFO pop strobe, one word per assertion.
REQ-009 SHALL provide port i_ready  input  1  downstream byte accept.
REQ-010 SHALL provide port O_serialized_output  output  8  current byte.
REQ-011 SHALL provide port O_serialized_output_valid  output  1  byte valid.
REQ-012 SHALL provide port O_Serialize_Counter  output  2  index (0..3) of current byte within its word.
REQ-013 SHALL provide port O_Bytes_Counter  output  16  bytes accepted downstream in current buffer.
REQ-014 SHALL provide port o_busy  output  1  high in every state except IDLE.
REQ-015 SHALL provide port o_done  output  1  one-cycle pulse at buffer completion.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, LOAD, SHIFT, DONE.
REQ-017 IDLE: on i_start, SHALL latch length into words_left, clear O_Bytes_Counter and O_Serialize_Counter, go FETCH; length 0 -> DONE directly, no FIFO reads.
REQ-018 i_start outside IDLE SHALL be ignored with no state change.
REQ-019 FETCH: SHALL assert o_FIFO_rd_en combinationally iff i_FIFO_empty=0, then go LOAD; if empty, stay FETCH, rd_en=0.
REQ-020 LOAD: SHALL capture i_FIFO_rd_data into a 32-bit holding register, go SHIFT; o_FIFO_rd_en=0.
REQ-021 SHIFT: SHALL drive valid=1 and byte[O_Serialize_Counter] per LITTLE_ENDIAN.
REQ-022 SHIFT with i_ready=0: byte, counter and valid SHALL hold stable.
REQ-023 SHIFT with i_ready=1: SHALL increment O_Serialize_Counter (mod 4) and O_Bytes_Counter by 1.
REQ-024 Accept at counter 3: SHALL decrement words_left; if result 0 -> DONE, else -> FETCH.
REQ-025 DONE: SHALL assert o_done for exactly one cycle, valid=0, then IDLE; O_Bytes_Counter SHALL hold its final value until next accepted i_start.
REQ-026 O_serialized_output_valid SHALL be 0 in IDLE, FETCH, LOAD, DONE.
REQ-027 o_FIFO_rd_en SHALL never assert more than length times per buffer, nor outside FETCH.
REQ-028 Per-word latency from FETCH with non-empty FIFO to first valid byte SHALL be 2 cycles; full-speed throughput SHALL be 4 bytes per 6 cycles.
REQ-029 O_Bytes_Counter SHALL equal 4*length at DONE (max 252); no overflow handling required.

Reset
REQ-030 HRESET high at a rising HCLK edge SHALL force IDLE, o_FIFO_rd_en=0, valid=0, O_serialized_output=0, O_Serialize_Counter=0, O_Bytes_Counter=0, o_busy=0, o_done=0, holding register=0, words_left=0.
REQ-031 HRESET in any state, mid-word included, SHALL abort the buffer with no o_done pulse and no further FIFO reads.

Verification
REQ-032 Length 1, FIFO word 0x44332211, i_ready=1, LITTLE_ENDIAN=1 -> bytes 11,22,33,44 on consecutive cycles, counter 0..3, O_Bytes_Counter=4, o_done one cycle later.
REQ-033 Same stimulus, LITTLE_ENDIAN=0 -> bytes 44,33,22,11.
REQ-034 Length 3, FIFO empty 5 cycles before second word -> stall in FETCH, rd_en low while empty, exactly 3 pops, 12 bytes, O_Bytes_Counter=12.
REQ-035 i_ready toggled 0/1 every cycle in SHIFT -> each byte held while i_ready=0, no byte lost or duplicated.
REQ-036 Length 0 -> o_done 1 cycle after start, zero rd_en, zero valid; i_start during busy -> ignored.
REQ-037 HRESET asserted at byte 2 of word 2 -> next cycle IDLE, all outputs zero, no o_done.
